alarme_ctrl: RTL and testbench

//   Sequencing controller for the 4-sensor alarm decoder (alarme). Takes the decoder's

---
 rtl/alarme_ctrl.sv | 82 ++++++++
 tb/tb_alarme_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/alarme_ctrl.sv
// alarme_ctrl: arm/disarm sequencer with exit delay, entry delay and timed siren
module alarme_ctrl #(
  parameter int EXIT_CYCLES  = 16,
  parameter int ENTRY_CYCLES = 8,
  parameter int SIREN_CYCLES = 32,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arm,
  input  logic       disarm,
  input  logic       sensor_s,
  input  logic       porta,
  output logic       sirene,
  output logic       armado,
  output logic [2:0] estado,
  output logic [3:0] ocorrencias
);
  typedef enum logic [2:0] {
    DESARMADO = 3'd0,
    ARMANDO   = 3'd1,
    ARMADO    = 3'd2,
    ENTRADA   = 3'd3,
    DISPARADO = 3'd4
  } state_t;
  localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_CYCLES - 1);
  localparam logic [CNT_W-1:0] SIREN_LD = CNT_W'(SIREN_CYCLES - 1);
  state_t state, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic cnt_zero;
  assign cnt_zero = cnt == '0;
  // Next state and delay counter; disarm beats everything, unknown codes fall back to DESARMADO
  always_comb begin
    nxt     = DESARMADO;
    cnt_nxt = cnt;
    if (!disarm) begin
      case (state)
        DESARMADO: begin
          nxt     = arm ? ARMANDO : DESARMADO;
          cnt_nxt = arm ? EXIT_LD : cnt;
        end
        ARMANDO: begin
          nxt     = cnt_zero ? ARMADO : ARMANDO;
          cnt_nxt = cnt_zero ? cnt : cnt - 1'b1;
        end
        ARMADO: begin
          nxt     = sensor_s ? DISPARADO : porta ? ENTRADA : ARMADO;
          cnt_nxt = sensor_s ? SIREN_LD : porta ? ENTRY_LD : cnt;
        end
        ENTRADA: begin
          nxt     = (sensor_s || cnt_zero) ? DISPARADO : ENTRADA;
          cnt_nxt = (sensor_s || cnt_zero) ? SIREN_LD : cnt - 1'b1;
        end
        DISPARADO: begin
          nxt     = cnt_zero ? ARMADO : DISPARADO;
          cnt_nxt = cnt_zero ? cnt : cnt - 1'b1;
        end
        default: nxt = DESARMADO;
      endcase
    end
  end
  // State, counter and Moore outputs registered together from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= DESARMADO;
      cnt         <= '0;
      estado      <= 3'd0;
      sirene      <= 1'b0;
      armado      <= 1'b0;
      ocorrencias <= 4'd0;
    end else begin
      state  <= nxt;
      cnt    <= cnt_nxt;
      estado <= nxt;
      sirene <= nxt == DISPARADO;
      armado <= nxt inside {ARMADO, ENTRADA, DISPARADO};
      if (nxt == DISPARADO && state != DISPARADO && ocorrencias != 4'd15)
        ocorrencias <= ocorrencias + 4'd1;
    end
  end
endmodule

// File: tb/tb_alarme_ctrl.sv
// tb_alarme_ctrl: directed stimulus checked against an elapsed-time model of the alarm cycle
module tb_alarme_ctrl;
  localparam int EXIT  = 4;
  localparam int ENTRY = 3;
  localparam int SIREN = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic arm = 1'b0, disarm = 1'b0, sensor_s = 1'b0, porta = 1'b0;
  logic sirene, armado;
  logic [2:0] estado;
  logic [3:0] ocorrencias;
  int n_cmp = 0;
  int n_bad = 0;
  int m_st = 0;
  int m_age = 0;
  int m_occ = 0;
  alarme_ctrl #(.EXIT_CYCLES(EXIT), .ENTRY_CYCLES(ENTRY), .SIREN_CYCLES(SIREN), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .disarm(disarm), .sensor_s(sensor_s), .porta(porta),
    .sirene(sirene), .armado(armado), .estado(estado), .ocorrencias(ocorrencias)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask
  // Model: each state is left after it has been occupied for its full duration in cycles
  function automatic int next_st(int st, int age, logic a, logic d, logic s, logic p);
    if (d) return 0;
    case (st)
      0: return a ? 1 : 0;
      1: return (age + 1 == EXIT) ? 2 : 1;
      2: return s ? 4 : (p ? 3 : 2);
      3: return (s || age + 1 == ENTRY) ? 4 : 3;
      4: return (age + 1 == SIREN) ? 2 : 4;
      default: return 0;
    endcase
  endfunction
  always @(posedge clk) begin
    if (!rst_n) begin
      m_st  <= 0;
      m_age <= 0;
      m_occ <= 0;
    end else begin
      m_st  <= next_st(m_st, m_age, arm, disarm, sensor_s, porta);
      m_age <= (next_st(m_st, m_age, arm, disarm, sensor_s, porta) == m_st) ? m_age + 1 : 0;
      if (next_st(m_st, m_age, arm, disarm, sensor_s, porta) == 4 && m_st != 4 && m_occ < 15)
        m_occ <= m_occ + 1;
    end
  end
  // Every cycle: outputs must follow the model state
  always @(negedge clk) begin
    chk("estado", 8'(estado), 8'(m_st));
    chk("armado", 8'(armado), 8'(m_st >= 2 && m_st <= 4));
    chk("sirene", 8'(sirene), 8'(m_st == 4));
    chk("ocorrencias", 8'(ocorrencias), 8'(m_occ));
  end
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    step(2);
    rst_n = 1'b1;
    chk("lit_reset_estado", 8'(estado), 8'd0);
    chk("lit_reset_ocorr", 8'(ocorrencias), 8'd0);
    arm = 1'b1; sensor_s = 1'b1;
    step(1);
    arm = 1'b0;
    chk("lit_armando_first", 8'(estado), 8'd1);
    step(3);
    chk("lit_armando_last", 8'(estado), 8'd1);
    sensor_s = 1'b0;
    step(1);
    chk("lit_armado", 8'(estado), 8'd2);
    chk("lit_armando_no_trig", 8'(ocorrencias), 8'd0);
    porta = 1'b1;
    step(1);
    porta = 1'b0;
    step(2);
    chk("lit_entrada_last", 8'(estado), 8'd3);
    step(1);
    chk("lit_disparo", 8'(estado), 8'd4);
    chk("lit_sirene_on", 8'(sirene), 8'd1);
    step(4);
    chk("lit_sirene_last", 8'(sirene), 8'd1);
    step(1);
    chk("lit_rearm_estado", 8'(estado), 8'd2);
    chk("lit_rearm_sirene", 8'(sirene), 8'd0);
    chk("lit_rearm_ocorr", 8'(ocorrencias), 8'd1);
    porta = 1'b1;
    step(1);
    porta = 1'b0;
    step(1);
    sensor_s = 1'b1;
    step(1);
    sensor_s = 1'b0;
    chk("lit_entry_sensor", 8'(estado), 8'd4);
    chk("lit_entry_sensor_ocorr", 8'(ocorrencias), 8'd2);
    disarm = 1'b1;
    step(1);
    disarm = 1'b0;
    chk("lit_disarm_siren", 8'(estado), 8'd0);
    arm = 1'b1;
    step(1);
    arm = 1'b0;
    step(4);
    chk("lit_armado2", 8'(estado), 8'd2);
    porta = 1'b1;
    step(1);
    porta = 1'b0;
    disarm = 1'b1;
    step(1);
    disarm = 1'b0;
    chk("lit_disarm_entry", 8'(estado), 8'd0);
    chk("lit_disarm_entry_ocorr", 8'(ocorrencias), 8'd2);
    arm = 1'b1; disarm = 1'b1;
    step(1);
    arm = 1'b0; disarm = 1'b0;
    chk("lit_arm_and_disarm", 8'(estado), 8'd0);
    arm = 1'b1;
    step(1);
    arm = 1'b0;
    step(4);
    sensor_s = 1'b1; porta = 1'b1;
    step(1);
    porta = 1'b0;
    chk("lit_sensor_wins", 8'(estado), 8'd4);
    chk("lit_sensor_wins_ocorr", 8'(ocorrencias), 8'd3);
    step(6 * 14);
    chk("lit_sat_estado", 8'(estado), 8'd4);
    chk("lit_sat_ocorr", 8'(ocorrencias), 8'd15);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1; sensor_s = 1'b0;
    chk("lit_rst_estado", 8'(estado), 8'd0);
    chk("lit_rst_sirene", 8'(sirene), 8'd0);
    chk("lit_rst_armado", 8'(armado), 8'd0);
    chk("lit_rst_ocorr", 8'(ocorrencias), 8'd0);
    step(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
